// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU control codes, forwarding selects and default widths
package id_ex_stage_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 3;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: combinational forwarding selects and stall detection for the EX stage
//   in : rs_e/rt_e/write_reg_e/regwrite_e/mem_to_reg_e (EX regs), rs_d/rt_d (decode),
//        write_reg_m/regwrite_m, write_reg_w/regwrite_w (later stages)
//   out: fwd_a, fwd_b (00 reg, 01 WB, 10 MEM), lw_stall
//   ID_EX_FORWARDING_EN defined: MEM/WB forwarding plus load-use stall;
//   undefined: no forwarding, stall on any RAW dependency against the EX destination.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] rs_e,
  input  logic [RADDR_W-1:0] rt_e,
  input  logic [RADDR_W-1:0] write_reg_e,
  input  logic               regwrite_e,
  input  logic               mem_to_reg_e,
  input  logic [RADDR_W-1:0] rs_d,
  input  logic [RADDR_W-1:0] rt_d,
  input  logic [RADDR_W-1:0] write_reg_m,
  input  logic               regwrite_m,
  input  logic [RADDR_W-1:0] write_reg_w,
  input  logic               regwrite_w,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               lw_stall
);
`ifdef ID_EX_FORWARDING_EN
  // MEM is checked first so the youngest producer wins; $0 is never forwarded.
  assign fwd_a = (regwrite_m && |write_reg_m && write_reg_m == rs_e) ? FWD_MEM :
                 (regwrite_w && |write_reg_w && write_reg_w == rs_e) ? FWD_WB : FWD_REG;
  assign fwd_b = (regwrite_m && |write_reg_m && write_reg_m == rt_e) ? FWD_MEM :
                 (regwrite_w && |write_reg_w && write_reg_w == rt_e) ? FWD_WB : FWD_REG;
  assign lw_stall = mem_to_reg_e & ((rt_e == rs_d) | (rt_e == rt_d));
  logic unused_nofwd;
  assign unused_nofwd = ^{write_reg_e, regwrite_e};
`else
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign lw_stall = regwrite_e & (|write_reg_e) & ((write_reg_e == rs_d) | (write_reg_e == rt_d));
  logic unused_fwd;
  assign unused_fwd = ^{rs_e, rt_e, mem_to_reg_e, write_reg_m, regwrite_m, write_reg_w, regwrite_w};
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding muxes feeding the ALU
//   in : clk, reset (sync, active-high), StallE, FlushE, decode operands/indices/controls,
//        ALUOutM/WriteRegM/RegWriteM, ResultW/WriteRegW/RegWriteW
//   out: SrcAE, SrcBE, ALUControlE, WriteDataE, WriteRegE, RegWriteE, MemtoRegE,
//        MemWriteE, ForwardAE, ForwardBE, LwStallD
//   ID_EX_FORWARDING_EN selects forwarding (see fwd_unit); default build forwards nothing.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [WIDTH-1:0]   RD1D,
  input  logic [WIDTH-1:0]   RD2D,
  input  logic [WIDTH-1:0]   SignImmD,
  input  logic [RADDR_W-1:0] RsD,
  input  logic [RADDR_W-1:0] RtD,
  input  logic [RADDR_W-1:0] RdD,
  input  logic [CTRL_W-1:0]  ALUControlD,
  input  logic               ALUSrcD,
  input  logic               RegDstD,
  input  logic               RegWriteD,
  input  logic               MemtoRegD,
  input  logic               MemWriteD,
  input  logic [WIDTH-1:0]   ALUOutM,
  input  logic [RADDR_W-1:0] WriteRegM,
  input  logic               RegWriteM,
  input  logic [WIDTH-1:0]   ResultW,
  input  logic [RADDR_W-1:0] WriteRegW,
  input  logic               RegWriteW,
  output logic [WIDTH-1:0]   SrcAE,
  output logic [WIDTH-1:0]   SrcBE,
  output logic [CTRL_W-1:0]  ALUControlE,
  output logic [WIDTH-1:0]   WriteDataE,
  output logic [RADDR_W-1:0] WriteRegE,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               LwStallD
);
  logic [WIDTH-1:0] rd1_e, rd2_e, imm_e;
  logic [RADDR_W-1:0] rs_e, rt_e, rd_e;
  logic alu_src_e, reg_dst_e;
  // A flush loads the same all-zero bubble as reset, so it never writes state downstream.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      rd1_e <= '0;
      rd2_e <= '0;
      imm_e <= '0;
      rs_e <= '0;
      rt_e <= '0;
      rd_e <= '0;
      ALUControlE <= '0;
      alu_src_e <= 1'b0;
      reg_dst_e <= 1'b0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
    end else if (!StallE) begin
      rd1_e <= RD1D;
      rd2_e <= RD2D;
      imm_e <= SignImmD;
      rs_e <= RsD;
      rt_e <= RtD;
      rd_e <= RdD;
      ALUControlE <= ALUControlD;
      alu_src_e <= ALUSrcD;
      reg_dst_e <= RegDstD;
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      MemWriteE <= MemWriteD;
    end
  end
  assign WriteRegE = reg_dst_e ? rd_e : rt_e;
  fwd_unit #(.RADDR_W(RADDR_W)) u_fwd (
    .rs_e(rs_e),
    .rt_e(rt_e),
    .write_reg_e(WriteRegE),
    .regwrite_e(RegWriteE),
    .mem_to_reg_e(MemtoRegE),
    .rs_d(RsD),
    .rt_d(RtD),
    .write_reg_m(WriteRegM),
    .regwrite_m(RegWriteM),
    .write_reg_w(WriteRegW),
    .regwrite_w(RegWriteW),
    .fwd_a(ForwardAE),
    .fwd_b(ForwardBE),
    .lw_stall(LwStallD)
  );
  always_comb begin
    SrcAE = (ForwardAE == FWD_MEM) ? ALUOutM : (ForwardAE == FWD_WB) ? ResultW : rd1_e;
    WriteDataE = (ForwardBE == FWD_MEM) ? ALUOutM : (ForwardBE == FWD_WB) ? ResultW : rd2_e;
    SrcBE = alu_src_e ? imm_e : WriteDataE;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a transaction-level model
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0] rs, rt, rd;
    logic [2:0] ctl;
    logic alusrc, regdst, regwrite, memtoreg, memwrite;
  } txn_t;
  logic clk = 1'b0, reset = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  txn_t d = '0, em = '0;
  logic [31:0] ALUOutM = '0, ResultW = '0;
  logic [4:0] WriteRegM = '0, WriteRegW = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0] ALUControlE;
  logic [4:0] WriteRegE;
  logic RegWriteE, MemtoRegE, MemWriteE, LwStallD;
  logic [1:0] ForwardAE, ForwardBE;
  int checks = 0, errors = 0;
`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  id_ex_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RD1D(d.rd1), .RD2D(d.rd2), .SignImmD(d.imm),
    .RsD(d.rs), .RtD(d.rt), .RdD(d.rd), .ALUControlD(d.ctl),
    .ALUSrcD(d.alusrc), .RegDstD(d.regdst), .RegWriteD(d.regwrite),
    .MemtoRegD(d.memtoreg), .MemWriteD(d.memwrite),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LwStallD(LwStallD)
  );
  always #5 clk = ~clk;
  function automatic txn_t rand_txn(int maxreg);
    txn_t t;
    logic [2:0] ops [5];
    ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_ADD; ops[3] = ALU_SUB; ops[4] = ALU_SLT;
    t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
    t.rs = 5'($urandom_range(0, maxreg)); t.rt = 5'($urandom_range(0, maxreg));
    t.rd = 5'($urandom_range(0, maxreg));
    t.ctl = ops[$urandom_range(0, 4)];
    {t.alusrc, t.regdst, t.regwrite, t.memtoreg, t.memwrite} = 5'($urandom);
    return t;
  endfunction
  function automatic logic [1:0] fsel(logic [4:0] r);
    if (FWD && RegWriteM && WriteRegM != 0 && WriteRegM == r) return 2'd2;
    if (FWD && RegWriteW && WriteRegW != 0 && WriteRegW == r) return 2'd1;
    return 2'd0;
  endfunction
  function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] v);
    return s == 2'd2 ? ALUOutM : s == 2'd1 ? ResultW : v;
  endfunction
  function automatic logic exp_stall();
    logic [4:0] wr;
    wr = em.regdst ? em.rd : em.rt;
    if (FWD) return em.memtoreg && (em.rt == d.rs || em.rt == d.rt);
    return em.regwrite && wr != 0 && (wr == d.rs || wr == d.rt);
  endfunction
  task automatic tick();
    @(posedge clk);
    if (reset || FlushE) em = '0;
    else if (!StallE) em = d;
    #1;
  endtask
  task automatic mw_off();
    RegWriteM = 1'b0; RegWriteW = 1'b0; WriteRegM = '0; WriteRegW = '0;
    ALUOutM = '0; ResultW = '0;
  endtask
  task automatic test_reset();
    d = rand_txn(31);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({SrcAE, SrcBE, WriteDataE, WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h %h %h %b%b%b exp all zero", SrcAE, SrcBE, WriteDataE,
               WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE);
    end
    checks++;
    if ({ForwardAE, ForwardBE, LwStallD} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hazard got %b %b %b exp 00 00 0", ForwardAE, ForwardBE, LwStallD);
    end
    reset = 1'b0;
  endtask
  task automatic test_mem_forward();
    mw_off();
    d = '0; d.rs = 5'd5; d.rd1 = 32'h3;
    tick();
    RegWriteM = 1'b1; WriteRegM = 5'd5; ALUOutM = 32'h10;
    #1;
    checks++;
    if (ForwardAE !== (FWD ? 2'b10 : 2'b00)) begin
      errors++;
      $display("FAIL mem_fwd_sel got %b exp %b", ForwardAE, FWD ? 2'b10 : 2'b00);
    end
    checks++;
    if (SrcAE !== (FWD ? 32'h10 : 32'h3)) begin
      errors++;
      $display("FAIL mem_fwd_srca got %h exp %h", SrcAE, FWD ? 32'h10 : 32'h3);
    end
  endtask
  task automatic test_priority_zero();
    mw_off();
    d = '0; d.rt = 5'd7; d.rd2 = 32'h55;
    tick();
    RegWriteM = 1'b1; WriteRegM = 5'd7; ALUOutM = 32'hA;
    RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'hB;
    #1;
    checks++;
    if (ForwardBE !== (FWD ? 2'b10 : 2'b00)) begin
      errors++;
      $display("FAIL prio_sel got %b exp %b", ForwardBE, FWD ? 2'b10 : 2'b00);
    end
    checks++;
    if (SrcBE !== (FWD ? 32'hA : 32'h55) || WriteDataE !== SrcBE) begin
      errors++;
      $display("FAIL prio_srcb got %h/%h exp %h", SrcBE, WriteDataE, FWD ? 32'hA : 32'h55);
    end
    d.rt = 5'd0;
    tick();
    WriteRegM = 5'd0; WriteRegW = 5'd0;
    #1;
    checks++;
    if (ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL zero_sel got %b exp 00", ForwardBE);
    end
    checks++;
    if (SrcBE !== 32'h55) begin
      errors++;
      $display("FAIL zero_srcb got %h exp 00000055", SrcBE);
    end
  endtask
  task automatic test_load_use();
    mw_off();
    d = '0; d.memtoreg = 1'b1; d.regwrite = 1'b1; d.rt = 5'd8;
    tick();
    d = '0; d.rs = 5'd8; d.rt = 5'd9;
    #1;
    checks++;
    if (LwStallD !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %b exp 1", LwStallD);
    end
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++;
    if ({MemtoRegE, RegWriteE, LwStallD} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_flush got %b%b%b exp 000", MemtoRegE, RegWriteE, LwStallD);
    end
  endtask
  task automatic test_stall_flush();
    mw_off();
    d = '0;
    d.rd1 = 32'h11; d.rd2 = 32'h22; d.imm = 32'h33; d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3;
    d.ctl = ALU_OR; d.regdst = 1'b1; d.regwrite = 1'b1; d.memwrite = 1'b1;
    tick();
    d = rand_txn(31);
    StallE = 1'b1;
    tick();
    checks++;
    if ({SrcAE, SrcBE, WriteDataE, WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE} !==
        {32'h11, 32'h22, 32'h22, 5'd3, ALU_OR, 3'b101}) begin
      errors++;
      $display("FAIL stall_hold got %h %h %h %h %h %b%b%b exp 11 22 22 3 1 101", SrcAE, SrcBE,
               WriteDataE, WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE);
    end
    FlushE = 1'b1;
    tick();
    checks++;
    if ({SrcAE, SrcBE, WriteDataE, WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE, LwStallD} !== '0) begin
      errors++;
      $display("FAIL stall_flush_bubble got %h %h %h %h %h %b%b%b%b exp all zero", SrcAE, SrcBE,
               WriteDataE, WriteRegE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE, LwStallD);
    end
    StallE = 1'b0; FlushE = 1'b0;
  endtask
  task automatic test_immediate();
    mw_off();
    d = rand_txn(31);
    d.alusrc = 1'b1; d.imm = 32'hFFFFFFFC; d.ctl = ALU_ADD;
    tick();
    checks++;
    if (SrcBE !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL imm_srcb got %h exp fffffffc", SrcBE);
    end
    checks++;
    if (ALUControlE !== ALU_ADD) begin
      errors++;
      $display("FAIL imm_ctl got %b exp 010", ALUControlE);
    end
  endtask
  task automatic test_random();
    logic [1:0] fa, fb;
    logic [31:0] wd;
    logic [4:0] wr;
    for (int i = 0; i < 400; i++) begin
      d = rand_txn(3);
      reset = ($urandom_range(0, 31) == 0);
      StallE = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      tick();
      RegWriteM = 1'($urandom); WriteRegM = 5'($urandom_range(0, 3)); ALUOutM = $urandom;
      RegWriteW = 1'($urandom); WriteRegW = 5'($urandom_range(0, 3)); ResultW = $urandom;
      #1;
      fa = fsel(em.rs);
      fb = fsel(em.rt);
      wd = pick(fb, em.rd2);
      wr = em.regdst ? em.rd : em.rt;
      checks++;
      if ({ForwardAE, ForwardBE, SrcAE, SrcBE, WriteDataE, WriteRegE, ALUControlE, RegWriteE,
           MemtoRegE, MemWriteE, LwStallD} !==
          {fa, fb, pick(fa, em.rd1), em.alusrc ? em.imm : wd, wd, wr, em.ctl, em.regwrite,
           em.memtoreg, em.memwrite, exp_stall()}) begin
        errors++;
        $display("FAIL random[%0d] got fa%b fb%b a%h b%h wd%h wr%h c%h %b%b%b ls%b exp fa%b fb%b a%h b%h wd%h wr%h c%h %b%b%b ls%b",
                 i, ForwardAE, ForwardBE, SrcAE, SrcBE, WriteDataE, WriteRegE, ALUControlE,
                 RegWriteE, MemtoRegE, MemWriteE, LwStallD, fa, fb, pick(fa, em.rd1),
                 em.alusrc ? em.imm : wd, wd, wr, em.ctl, em.regwrite, em.memtoreg,
                 em.memwrite, exp_stall());
      end
    end
    reset = 1'b0; StallE = 1'b0; FlushE = 1'b0;
  endtask
  initial begin
    test_reset();
    test_mem_forward();
    test_priority_zero();
    test_load_use();
    test_stall_flush();
    test_immediate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the pipelined MIPS core.
- Latches decode-stage operands and control signals, resolves RAW hazards by forwarding from the MEM and WB stages, and detects load-use hazards.
- Drives the ALU's SrcA, SrcB and 3-bit Control inputs in the execute stage.

Parameters:
- WIDTH, 32, datapath width.
- RADDR_W, 5, register index width.
- CTRL_W, 3, ALU control width (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
StallE  in  1  hold all E registers
FlushE  in  1  load a bubble into E registers
RD1D  in  WIDTH  register-file read data, Rs
RD2D  in  WIDTH  register-file read data, Rt
SignImmD  in  WIDTH  sign-extended immediate
RsD, RtD, RdD  in  RADDR_W each  register indices
ALUControlD  in  CTRL_W  ALU operation
ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD  in  1 each  decoded control
ALUOutM  in  WIDTH  MEM-stage ALU result
WriteRegM  in  RADDR_W  MEM destination register
RegWriteM  in  1  MEM writes register
ResultW  in  WIDTH  WB result
WriteRegW  in  RADDR_W  WB destination register
RegWriteW  in  1  WB writes register
SrcAE  out  WIDTH  ALU operand A
SrcBE  out  WIDTH  ALU operand B
ALUControlE  out  CTRL_W  ALU control
WriteDataE  out  WIDTH  forwarded Rt value for stores
WriteRegE  out  RADDR_W  EX destination register
RegWriteE, MemtoRegE, MemWriteE  out  1 each  control forwarded downstream
ForwardAE, ForwardBE  out  2 each  mux selects (00 reg, 01 WB, 10 MEM)
LwStallD  out  1  load-use hazard; hazard unit stalls F/D and flushes E

Behaviour:
- Register update priority on each rising clk edge: reset > FlushE > StallE > load from D inputs.
- reset: all E registers clear to 0. All control outputs are 0, ALUControlE=000, and data/index registers are 0.
- FlushE (takes precedence over StallE when both are asserted): same all-zero bubble as reset. A bubble never writes a register or memory.
- StallE without FlushE: every E register holds its value.
- Latency: D inputs appear at E outputs one cycle after capture. Forwarding and operand muxing are combinational from the E registers and the M/W inputs.
- ForwardAE selection:
  - 10 if RegWriteM and WriteRegM!=0 and WriteRegM==RsE;
  - else 01 if RegWriteW and WriteRegW!=0 and WriteRegW==RsE;
  - else 00.
  - MEM has priority over WB when both match. ForwardBE uses the same rule on RtE.
- Register $0 is never forwarded.
- Operands: SrcAE = mux(RD1E, ResultW, ALUOutM) by ForwardAE. WriteDataE = same mux on RD2E by ForwardBE. SrcBE = ALUSrcE ? SignImmE : WriteDataE.
- WriteRegE = RegDstE ? RdE : RtE.
- LwStallD = MemtoRegE & ((RtE==RsD) | (RtE==RtD)). This is combinational and is 0 after reset or a flush.
- All arithmetic is width-exact; there are no extensions inside the block.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN
- Defined: full forwarding muxes and load-use detection, as described above.
- Undefined:
  - Forwarding logic is removed; ForwardAE/BE are tied to 00 and SrcAE=RD1E, WriteDataE=RD2E.
  - LwStallD widens to a general RAW stall: RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD).
  - The hazard unit reacts identically, and the register file handles the WB write-before-read.

Decomposition:
- Shared package holds:
  - ALU control localparams (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111);
  - forwarding select constants FWD_REG/FWD_WB/FWD_MEM;
  - WIDTH and RADDR_W defaults.
- One natural sub-module: fwd_unit, which computes ForwardAE/BE and LwStallD combinationally. The pipeline registers and operand muxes stay in id_ex_stage.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary D inputs -> all E outputs 0, LwStallD=0.
- MEM forward: RsE=5, RegWriteM=1, WriteRegM=5, ALUOutM=0x10, RD1E=0x3 -> ForwardAE=10, SrcAE=0x10.
- Priority and $0:
  - M and W both target Rt=7 (ALUOutM=0xA, ResultW=0xB), ALUSrcE=0 -> ForwardBE=10, SrcBE=0xA.
  - Repeat with index 0 -> ForwardBE=00.
- Load-use: E holds lw (MemtoRegE=1, RtE=8), RsD=8 -> LwStallD=1. Next edge with FlushE=1 -> MemtoRegE=0, RegWriteE=0, LwStallD=0.
- Stall vs flush:
  - StallE=1 with new D inputs -> E values unchanged.
  - StallE=1 and FlushE=1 together -> bubble loaded.
- Immediate path: ALUSrcD=1, SignImmD=0xFFFFFFFC, ALUControlD=010 -> next cycle SrcBE=0xFFFFFFFC, ALUControlE=010. With ID_EX_FORWARDING_EN undefined, ForwardAE/BE stay 00 in every scenario above.
